// File: rtl/io_capture_replay_pkg.sv
// Shared types and constants for the IO capture/replay block.
//   mode_e  : synchronised host mode decode carried on uio_in[2:1]
//   state_e : controller state
//   Stat*   : bit positions of the status flags on uio_out
package io_capture_replay_pkg;

   typedef enum logic [1:0] {
      ModeIdle       = 2'b00,
      ModeCapture    = 2'b01,
      ModeReplayOnce = 2'b10,
      ModeReplayLoop = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StCapture = 2'b01,
      StReplay  = 2'b10
   } state_e;

   localparam int unsigned StatFullBit  = 7;
   localparam int unsigned StatEmptyBit = 6;
   localparam int unsigned StatOvfBit   = 5;
   localparam int unsigned StatBusyBit  = 4;

   // Upper nibble of uio is driven (status), lower nibble is input (strobe/mode).
   localparam logic [7:0] UioOeValue = 8'hF0;

endpackage

// File: rtl/io_capture_replay_if.sv
// Pin bundle of the IO capture/replay block.
//   ena     : design enable
//   ui_in   : capture data (WIDTH)
//   uio_in  : [0] strobe, [2:1] mode
//   uo_out  : replayed / echoed data (WIDTH)
//   uio_out : [7] full, [6] empty, [5] overflow, [4] busy
//   uio_oe  : output enables for uio
// master = host side, slave = the block.
interface io_capture_replay_if #(
   parameter int unsigned WIDTH = 8
);

   logic             ena;
   logic [WIDTH-1:0] ui_in;
   logic [7:0]       uio_in;
   logic [WIDTH-1:0] uo_out;
   logic [7:0]       uio_out;
   logic [7:0]       uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );

endinterface

// File: rtl/io_capture_fifo.sv
// Circular word store for io_capture_replay.
// Ports:
//   clk, rst_n   : clock, async active-low reset (pointers and count only)
//   push/push_data : write one word; ignored when full
//   pop          : drop the oldest word; ignored when empty
//   clear        : empty the store in one cycle
//   peek_idx/peek_data : combinational read at any absolute slot
//   rd_ptr       : slot of the oldest word
//   count/full/empty : occupancy
module io_capture_fifo
   import io_capture_replay_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   input  logic [AW-1:0]    peek_idx,
   output logic [WIDTH-1:0] peek_data,
   output logic [AW-1:0]    rd_ptr,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (clear) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data;
   end

   assign peek_data = mem_q[peek_idx];
   assign rd_ptr    = rd_q;
   assign count     = count_q;

endmodule

// File: rtl/io_capture_replay.sv
// IO capture/replay: words strobed in on ui_in are stored in a FIFO and later played
// back on uo_out, once (destructive) or in a loop, one word every REPLAY_DIV cycles.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : async active-low reset
//   pins  : io_capture_replay_if.slave (ena, ui_in, uio_in, uo_out, uio_out, uio_oe)
// Build option: define IOCR_ECHO_EN to have uo_out follow ui_in while capturing.
module io_capture_replay
   import io_capture_replay_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned REPLAY_DIV = 4
) (
   input logic                clk,
   input logic                rst_n,
   io_capture_replay_if.slave pins
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam logic [7:0]  DivLast = 8'(REPLAY_DIV - 1);

   logic             strobe_s1_q, strobe_s2_q, strobe_s3_q, strobe_edge_q;
   logic [1:0]       mode_s1_q, mode_s2_q;
   mode_e            mode_sync, mode_prev_q;
   state_e           state_q, state_d;
   logic [7:0]       div_q;
   logic [AW-1:0]    rp_q, last_idx, peek_idx, rd_ptr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] peek_data, uo_q;
   logic             full, empty, ovf_q;
   logic             in_replay, mode_changed, terminal, replay_step, push, pop, clear;
   logic [7:0]       status;
   logic             unused_uio;

   assign unused_uio = ^pins.uio_in[7:3];

   // Synchronisers and strobe edge detector run regardless of ena, so an edge
   // seen while disabled is consumed and lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_s1_q   <= 1'b0;
         strobe_s2_q   <= 1'b0;
         strobe_s3_q   <= 1'b0;
         strobe_edge_q <= 1'b0;
         mode_s1_q     <= 2'b00;
         mode_s2_q     <= 2'b00;
      end else begin
         strobe_s1_q   <= pins.uio_in[0];
         strobe_s2_q   <= strobe_s1_q;
         strobe_s3_q   <= strobe_s2_q;
         strobe_edge_q <= strobe_s2_q & ~strobe_s3_q;
         mode_s1_q     <= pins.uio_in[2:1];
         mode_s2_q     <= mode_s1_q;
      end
   end

   assign mode_sync = mode_e'(mode_s2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (pins.ena) begin
         unique case (state_q)
            StIdle: begin
               if (mode_sync == ModeCapture)   state_d = StCapture;
               else if (mode_s2_q[1] && !empty) state_d = StReplay;
            end
            StCapture: begin
               if (mode_sync == ModeIdle)      state_d = StIdle;
               else if (mode_s2_q[1] && !empty) state_d = StReplay;
            end
            StReplay: begin
               if (mode_sync == ModeIdle)         state_d = StIdle;
               else if (mode_sync == ModeCapture) state_d = StCapture;
               else if (empty)                    state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign in_replay    = (state_q == StReplay);
   assign mode_changed = (mode_sync != mode_prev_q);
   assign terminal     = (div_q == DivLast);
   // A mode change restarts the divider, so no word is emitted on that cycle.
   assign replay_step  = pins.ena & in_replay & ~mode_changed & terminal & ~empty
                         & (state_d == StReplay);
   assign pop          = replay_step & (mode_sync == ModeReplayOnce);
   assign push         = pins.ena & (state_q == StCapture) & strobe_edge_q;
   assign clear        = pins.ena & (state_q == StIdle) & strobe_edge_q;
   assign last_idx     = rd_ptr + count[AW-1:0] - 1'b1;
   assign peek_idx     = (mode_sync == ModeReplayLoop) ? rp_q : rd_ptr;

   io_capture_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (pins.ui_in),
      .pop       (pop),
      .clear     (clear),
      .peek_idx  (peek_idx),
      .peek_data (peek_data),
      .rd_ptr    (rd_ptr),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_prev_q <= ModeIdle;
         div_q       <= 8'd0;
         rp_q        <= '0;
         ovf_q       <= 1'b0;
         uo_q        <= '0;
      end else if (pins.ena) begin
         mode_prev_q <= mode_sync;

         if (!in_replay || mode_changed || state_d != StReplay || terminal) div_q <= 8'd0;
         else                                                              div_q <= div_q + 1'b1;

         // Loop pointer restarts at the oldest word on entry or mode change.
         if (!in_replay || mode_changed) begin
            rp_q <= rd_ptr;
         end else if (replay_step && mode_sync == ModeReplayLoop) begin
            rp_q <= (rp_q == last_idx) ? rd_ptr : rp_q + 1'b1;
         end

         if (clear)             ovf_q <= 1'b0;
         else if (push && full) ovf_q <= 1'b1;

         if (replay_step) begin
            uo_q <= peek_data;
         end
`ifdef IOCR_ECHO_EN
         else if (state_q == StCapture) begin
            uo_q <= pins.ui_in;
         end
`endif
      end
   end

   always_comb begin
      status               = 8'h00;
      status[StatFullBit]  = full;
      status[StatEmptyBit] = empty;
      status[StatOvfBit]   = ovf_q;
      status[StatBusyBit]  = (state_q != StIdle);
   end

   assign pins.uo_out  = uo_q;
   assign pins.uio_out = status;
   assign pins.uio_oe  = UioOeValue;

endmodule

// File: tb/tb_io_capture_replay.sv
// Directed bench for io_capture_replay (WIDTH=8, DEPTH=4, REPLAY_DIV=2).
module tb_io_capture_replay;

   logic        clk;
   logic        rst_n;
   int unsigned n_checks;
   int unsigned n_errors;

`ifdef IOCR_ECHO_EN
   localparam logic [7:0] OldUo = 8'h33;
`else
   localparam logic [7:0] OldUo = 8'h00;
`endif

   io_capture_replay_if #(.WIDTH(8)) bus ();

   io_capture_replay #(
      .WIDTH      (8),
      .DEPTH      (4),
      .REPLAY_DIV (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pins  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input logic [7:0] val);
      bus.ui_in     = val;
      bus.uio_in[0] = 1'b1;
      repeat (6) tick();
      bus.uio_in[0] = 1'b0;
      repeat (4) tick();
   endtask

   task automatic set_mode(input logic [1:0] m);
      bus.uio_in[2:1] = m;
      repeat (4) tick();
   endtask

   // Returns right after the first sample showing busy == level.
   task automatic wait_busy(input logic level);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (bus.uio_out[4] == level) seen = 1'b1;
      end
      check_eq("wait_busy", {31'd0, bus.uio_out[4]}, {31'd0, level});
   endtask

   // Called at the replay entry sample; words appear every 2 cycles, first in seq[7:0].
   task automatic check_replay(input string tag, input int n, input logic [47:0] seq);
      for (int i = 0; i < n; i++) begin
         repeat (2) tick();
         check_eq($sformatf("%s%0d", tag, i), {24'd0, bus.uo_out}, {24'd0, seq[i*8 +: 8]});
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.ena    = 1'b1;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      repeat (3) tick();
      check_eq("rst_uo",  {24'd0, bus.uo_out},  32'h00);
      check_eq("rst_uio", {24'd0, bus.uio_out}, 32'h40);
      check_eq("rst_oe",  {24'd0, bus.uio_oe},  32'hF0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Capture three words
      set_mode(2'b01);
      check_eq("cap_busy", {24'd0, bus.uio_out}, 32'h50);
      strobe(8'h11);
      strobe(8'h22);
      strobe(8'h33);
      check_eq("cap_count",  {29'd0, dut.u_fifo.count}, 32'd3);
      check_eq("cap_status", {24'd0, bus.uio_out}, 32'h10);
      check_eq("cap_uo",     {24'd0, bus.uo_out},  {24'd0, OldUo});

      // Replay once
      set_mode(2'b00);
      check_eq("idle_status", {24'd0, bus.uio_out}, 32'h00);
      bus.uio_in[2:1] = 2'b10;
      wait_busy(1'b1);
      check_eq("once_entry_uo", {24'd0, bus.uo_out}, {24'd0, OldUo});
      check_replay("once", 3, 48'h00_00_00_33_22_11);
      tick();
      check_eq("once_end_status", {24'd0, bus.uio_out}, 32'h40);
      check_eq("once_end_uo",     {24'd0, bus.uo_out},  32'h33);

      // Overflow: fifth word dropped
      set_mode(2'b01);
      strobe(8'hAA);
      strobe(8'hBB);
      strobe(8'hCC);
      strobe(8'hDD);
      strobe(8'hEE);
      check_eq("ovf_status", {24'd0, bus.uio_out}, 32'hB0);
      check_eq("ovf_count",  {29'd0, dut.u_fifo.count}, 32'd4);
      set_mode(2'b00);
      check_eq("ovf_idle", {24'd0, bus.uio_out}, 32'hA0);
      bus.uio_in[2:1] = 2'b10;
      wait_busy(1'b1);
      check_replay("ovf_once", 4, 48'h00_00_DD_CC_BB_AA);
      tick();
      check_eq("ovf_end", {24'd0, bus.uio_out}, 32'h60);

      // Strobe in idle clears fifo and overflow, uo_out untouched
      strobe(8'h00);
      check_eq("clr_status", {24'd0, bus.uio_out}, 32'h40);
      check_eq("clr_uo",     {24'd0, bus.uo_out},  32'hDD);

      // Loop replay
      set_mode(2'b01);
      strobe(8'h01);
      strobe(8'h02);
      set_mode(2'b00);
      bus.uio_in[2:1] = 2'b11;
      wait_busy(1'b1);
      check_replay("loop", 6, 48'h02_01_02_01_02_01);
      bus.uio_in[2:1] = 2'b00;
      wait_busy(1'b0);
      check_eq("loop_count", {29'd0, dut.u_fifo.count}, 32'd2);
      check_eq("loop_idle",  {24'd0, bus.uio_out}, 32'h00);

      // Strobes while disabled are lost
      set_mode(2'b01);
      bus.ena = 1'b0;
      strobe(8'h77);
      strobe(8'h88);
      bus.ena = 1'b1;
      tick();
      check_eq("ena_count",  {29'd0, dut.u_fifo.count}, 32'd2);
      check_eq("ena_status", {24'd0, bus.uio_out}, 32'h10);
      strobe(8'h99);
      check_eq("ena_resume_count", {29'd0, dut.u_fifo.count}, 32'd3);

      bus.ui_in = 8'h5A;
      tick();
`ifdef IOCR_ECHO_EN
      check_eq("echo", {24'd0, bus.uo_out}, 32'h5A);
`else
      check_eq("no_echo", {31'd0, (bus.uo_out == 8'h5A)}, 32'd0);
`endif

      // Asynchronous reset in the middle of a loop replay
      set_mode(2'b00);
      bus.uio_in[2:1] = 2'b11;
      wait_busy(1'b1);
      repeat (3) tick();
      check_eq("mid_uo", {24'd0, bus.uo_out}, 32'h01);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_uo",    {24'd0, bus.uo_out},  32'h00);
      check_eq("arst_uio",   {24'd0, bus.uio_out}, 32'h40);
      check_eq("arst_count", {29'd0, dut.u_fifo.count}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
